// File: rtl/stack_cpu_pkg.sv
// Shared definitions for the stack processor controller: opcodes, ALU ops,
// select encodings, FSM states and the per-state control word.
package stack_cpu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_NOT  = 3'b011;
  localparam logic [2:0] OP_PUSH = 3'b100;
  localparam logic [2:0] OP_POP  = 3'b101;
  localparam logic [2:0] OP_JMP  = 3'b110;
  localparam logic [2:0] OP_JZ   = 3'b111;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;

  localparam logic IORD_PC     = 1'b0;
  localparam logic IORD_IR     = 1'b1;
  localparam logic PC_SRC_INC  = 1'b0;
  localparam logic PC_SRC_IR   = 1'b1;
  localparam logic STK_SRC_MEM = 1'b0;
  localparam logic STK_SRC_ALU = 1'b1;

  typedef enum logic [3:0] {
    S_IF   = 4'd0,
    S_ID   = 4'd1,
    S_POPA = 4'd2,
    S_POPB = 4'd3,
    S_POPN = 4'd4,
    S_EXEC = 4'd5,
    S_PRD  = 4'd6,
    S_PWB  = 4'd7,
    S_PWR  = 4'd8,
    S_JMP  = 4'd9,
    S_JZ   = 4'd10,
    S_ERR  = 4'd11
  } state_t;

  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       a_load;
    logic       b_load;
    logic [1:0] alu_op;
    logic       stack_push;
    logic       stack_pop;
    logic       stack_src;
    logic       halted;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  // Control word for the state being entered; op and tos_zero are the values
  // seen on the transition edge (IR and TOS are stable across ID).
  function automatic ctrl_t ctrl_for(input state_t st, input logic [2:0] op,
                                     input logic tos_zero);
    ctrl_t c;
    c = CTRL_IDLE;
    case (st)
      S_IF: begin
        c.iord     = IORD_PC;
        c.mem_read = 1'b1;
        c.ir_write = 1'b1;
        c.pc_write = 1'b1;
        c.pc_src   = PC_SRC_INC;
      end
      S_POPA, S_POPN: begin
        c.stack_pop = 1'b1;
        c.a_load    = 1'b1;
      end
      S_POPB: begin
        c.stack_pop = 1'b1;
        c.b_load    = 1'b1;
      end
      S_EXEC: begin
        c.stack_push = 1'b1;
        c.stack_src  = STK_SRC_ALU;
        c.alu_op     = op[1:0];
      end
      S_PRD: begin
        c.iord     = IORD_IR;
        c.mem_read = 1'b1;
      end
      S_PWB: begin
        c.stack_push = 1'b1;
        c.stack_src  = STK_SRC_MEM;
      end
      S_PWR: begin
        c.iord      = IORD_IR;
        c.mem_write = 1'b1;
        c.stack_pop = 1'b1;
      end
      S_JMP: begin
        c.pc_write = 1'b1;
        c.pc_src   = PC_SRC_IR;
      end
      S_JZ: begin
        c.pc_write = tos_zero;
        c.pc_src   = PC_SRC_IR;
      end
      S_ERR:   c.halted = 1'b1;
      default: c = CTRL_IDLE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/stack_depth_cnt.sv
// Up/down stack occupancy counter with empty / at-least-two / full flags.
module stack_depth_cnt #(
  parameter int STACK_DEPTH = 8,
  parameter int DEPTH_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  output logic [DEPTH_W-1:0] depth,
  output logic               empty,
  output logic               ge2,
  output logic               full
);

  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(STACK_DEPTH);

  logic [DEPTH_W-1:0] depth_reg, depth_next;

  // Saturating at both ends keeps the counter sane even if a caller misbehaves.
  always_comb begin
    depth_next = depth_reg;
    if (push && depth_reg != DEPTH_MAX)
      depth_next = depth_reg + DEPTH_W'(1);
    else if (pop && depth_reg != '0)
      depth_next = depth_reg - DEPTH_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)
      depth_reg <= '0;
    else
      depth_reg <= depth_next;
  end

  assign depth = depth_reg;
  assign empty = (depth_reg == '0);
  assign ge2   = (depth_reg >= DEPTH_W'(2));
  assign full  = (depth_reg == DEPTH_MAX);

endmodule

// File: rtl/stack_cpu_ctrl.sv
// Multicycle Moore controller for the 8-bit stack processor: fetch, decode
// with stack-depth checks, execute, and a sticky ERR state on stack faults.
module stack_cpu_ctrl
  import stack_cpu_pkg::*;
#(
  parameter int STACK_DEPTH = 8,
  parameter int DEPTH_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         opcode,
  input  logic               tos_zero,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               pc_write,
  output logic               pc_src,
  output logic               a_load,
  output logic               b_load,
  output logic [1:0]         alu_op,
  output logic               stack_push,
  output logic               stack_pop,
  output logic               stack_src,
  output logic [DEPTH_W-1:0] depth,
  output logic               halted
);

  state_t             state_reg, state_next;
  ctrl_t              ctrl_reg;
  ctrl_t              ctrl_out;
  logic [DEPTH_W-1:0] depth_cnt;
  logic               empty, ge2, full;

  stack_depth_cnt #(
    .STACK_DEPTH(STACK_DEPTH),
    .DEPTH_W    (DEPTH_W)
  ) u_depth (
    .clk  (clk),
    .rst  (rst),
    .push (ctrl_out.stack_push),
    .pop  (ctrl_out.stack_pop),
    .depth(depth_cnt),
    .empty(empty),
    .ge2  (ge2),
    .full (full)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IF: state_next = S_ID;
      S_ID: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND: state_next = ge2 ? S_POPA : S_ERR;
          OP_NOT:  state_next = empty ? S_ERR : S_POPN;
          OP_PUSH: state_next = full ? S_ERR : S_PRD;
          OP_POP:  state_next = empty ? S_ERR : S_PWR;
          OP_JMP:  state_next = S_JMP;
          OP_JZ:   state_next = empty ? S_ERR : S_JZ;
          default: state_next = S_ERR;
        endcase
      end
      S_POPA: state_next = S_POPB;
      S_POPB: state_next = S_EXEC;
      S_POPN: state_next = S_EXEC;
      S_EXEC: state_next = S_IF;
      S_PRD:  state_next = S_PWB;
      S_PWB:  state_next = S_IF;
      S_PWR:  state_next = S_IF;
      S_JMP:  state_next = S_IF;
      S_JZ:   state_next = S_IF;
      S_ERR:  state_next = S_ERR;
      default: state_next = S_ERR;
    endcase
  end

  // Outputs are registered alongside the state, so they belong to the state
  // being entered rather than the one being left.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IF;
      ctrl_reg  <= ctrl_for(S_IF, opcode, tos_zero);
    end else begin
      state_reg <= state_next;
      ctrl_reg  <= ctrl_for(state_next, opcode, tos_zero);
    end
  end

  // Reset silences every strobe immediately, including the cycle rst rises.
  assign ctrl_out = rst ? CTRL_IDLE : ctrl_reg;

  assign iord       = ctrl_out.iord;
  assign mem_read   = ctrl_out.mem_read;
  assign mem_write  = ctrl_out.mem_write;
  assign ir_write   = ctrl_out.ir_write;
  assign pc_write   = ctrl_out.pc_write;
  assign pc_src     = ctrl_out.pc_src;
  assign a_load     = ctrl_out.a_load;
  assign b_load     = ctrl_out.b_load;
  assign alu_op     = ctrl_out.alu_op;
  assign stack_push = ctrl_out.stack_push;
  assign stack_pop  = ctrl_out.stack_pop;
  assign stack_src  = ctrl_out.stack_src;
  assign halted     = ctrl_out.halted;
  assign depth      = rst ? '0 : depth_cnt;

endmodule

// File: tb/tb_stack_cpu_ctrl.sv
// Bench for stack_cpu_ctrl: behavioural datapath plus 32x8 memory, with a
// scoreboard of expected stack pushes and memory writes.
module tb_stack_cpu_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] opcode;
  logic       tos_zero;
  logic       iord, mem_read, mem_write, ir_write, pc_write, pc_src;
  logic       a_load, b_load, stack_push, stack_pop, stack_src, halted;
  logic [1:0] alu_op;
  logic [3:0] depth;

  always #5 clk = ~clk;

  stack_cpu_ctrl #(.STACK_DEPTH(8), .DEPTH_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .tos_zero(tos_zero),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .a_load(a_load), .b_load(b_load), .alu_op(alu_op),
    .stack_push(stack_push), .stack_pop(stack_pop), .stack_src(stack_src),
    .depth(depth), .halted(halted)
  );

  // Behavioural datapath
  logic [7:0]  mem [0:31];
  logic [7:0]  init_mem [0:31];
  logic [7:0]  stk [0:15];
  logic [4:0]  sp, pc, addr;
  logic [7:0]  ir, a, b, rd, tos, alu_res, push_data;
  logic [12:0] strobes;

  assign tos       = (sp == 5'd0) ? 8'h00 : stk[sp - 5'd1];
  assign tos_zero  = (tos == 8'h00);
  assign opcode    = ir[7:5];
  assign addr      = iord ? ir[4:0] : pc;
  assign push_data = stack_src ? alu_res : rd;
  assign strobes   = {iord, mem_read, mem_write, ir_write, pc_write, pc_src,
                      a_load, b_load, alu_op, stack_push, stack_pop, stack_src};

  always_comb begin
    alu_res = 8'h00;
    case (alu_op)
      2'b00: alu_res = b + a;
      2'b01: alu_res = b - a;
      2'b10: alu_res = b & a;
      2'b11: alu_res = ~a;
      default: alu_res = 8'h00;
    endcase
  end

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_mem[i];
    end else begin
      if (mem_read) rd <= mem[addr];
      if (mem_write) mem[addr] <= tos;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      pc <= 5'd0; sp <= 5'd0; ir <= 8'h00; a <= 8'h00; b <= 8'h00;
    end else begin
      if (ir_write) ir <= rd;
      if (pc_write) pc <= pc_src ? ir[4:0] : pc + 5'd1;
      if (a_load) a <= tos;
      if (b_load) b <= tos;
      if (stack_push) begin
        stk[sp[3:0]] <= push_data;
        sp <= sp + 5'd1;
      end else if (stack_pop) begin
        sp <= sp - 5'd1;
      end
    end
  end

  int errors = 0;
  int checks = 0;
  logic [7:0]  push_q [$];
  logic [12:0] wr_q [$];

  // One clock; pushes and writes are checked against the scoreboard mid-cycle.
  task automatic tick();
    logic [7:0]  exp_d;
    logic [12:0] exp_w;
    @(negedge clk);
    if (stack_push) begin
      checks++;
      $display("push data=%02h depth=%0d", push_data, depth);
      if (push_q.size() == 0) begin
        errors++;
        $display("FAIL push_unexpected: got data=%02h, required no push", push_data);
      end else begin
        exp_d = push_q.pop_front();
        if (push_data !== exp_d) begin
          errors++;
          $display("FAIL push_data: got %02h, required %02h", push_data, exp_d);
        end
      end
    end
    if (mem_write) begin
      checks++;
      $display("write addr=%0d data=%02h", addr, tos);
      if (wr_q.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected: got addr=%0d data=%02h, required no write", addr, tos);
      end else begin
        exp_w = wr_q.pop_front();
        if ({addr, tos} !== exp_w) begin
          errors++;
          $display("FAIL write: got addr=%0d data=%02h, required addr=%0d data=%02h",
                   addr, tos, exp_w[12:8], exp_w[7:0]);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 32; i++) init_mem[i] = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_mem();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (strobes !== 13'd0 || halted !== 1'b0 || depth !== 4'd0) begin
      errors++;
      $display("FAIL reset_state: got strobes=%h halted=%b depth=%0d, required 0 0 0",
               strobes, halted, depth);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (!(mem_read === 1'b1 && ir_write === 1'b1 && pc_write === 1'b1 &&
          iord === 1'b0 && pc_src === 1'b0 && addr === 5'd0)) begin
      errors++;
      $display("FAIL reset_first_fetch: got strobes=%h addr=%0d, required IF fetch at 0",
               strobes, addr);
    end
  endtask

  task automatic test_add_pop();
    clear_mem();
    init_mem[0] = 8'h8F; init_mem[1] = 8'h90; init_mem[2] = 8'h00;
    init_mem[3] = 8'hB6; init_mem[4] = 8'hC4;
    init_mem[15] = 8'd7; init_mem[16] = 8'd10;
    push_q.push_back(8'd7); push_q.push_back(8'd10); push_q.push_back(8'd17);
    wr_q.push_back({5'd22, 8'd17});
    do_reset();
    repeat (16) tick();
    checks++;
    if (pc !== 5'd4 || depth !== 4'd0) begin
      errors++;
      $display("FAIL add_pop_pc_depth: got pc=%0d depth=%0d, required pc=4 depth=0", pc, depth);
    end
    checks++;
    if (mem[22] !== 8'd17) begin
      errors++;
      $display("FAIL add_pop_mem22: got %0d, required 17", mem[22]);
    end
    checks++;
    if (push_q.size() != 0 || wr_q.size() != 0) begin
      errors++;
      $display("FAIL add_pop_pending: got %0d pushes %0d writes left, required 0 0",
               push_q.size(), wr_q.size());
    end
    push_q.delete(); wr_q.delete();
  endtask

  task automatic test_sub_not();
    clear_mem();
    init_mem[0] = 8'h90; init_mem[1] = 8'h91; init_mem[2] = 8'h20;
    init_mem[3] = 8'h60; init_mem[4] = 8'hC4;
    init_mem[16] = 8'd10; init_mem[17] = 8'd3;
    push_q.push_back(8'd10); push_q.push_back(8'd3);
    push_q.push_back(8'd7); push_q.push_back(8'hF8);
    do_reset();
    repeat (13) tick();
    checks++;
    if (tos !== 8'd7 || depth !== 4'd1) begin
      errors++;
      $display("FAIL sub_result: got tos=%02h depth=%0d, required 07 1", tos, depth);
    end
    repeat (4) tick();
    checks++;
    if (tos !== 8'hF8 || depth !== 4'd1 || halted !== 1'b0) begin
      errors++;
      $display("FAIL not_result: got tos=%02h depth=%0d halted=%b, required f8 1 0",
               tos, depth, halted);
    end
    checks++;
    if (push_q.size() != 0) begin
      errors++;
      $display("FAIL sub_not_pending: got %0d pushes left, required 0", push_q.size());
    end
    push_q.delete();
  endtask

  task automatic test_jz(input logic [7:0] val, input logic [4:0] exp_pc);
    clear_mem();
    init_mem[0] = 8'h94; init_mem[1] = 8'hE5;
    init_mem[2] = 8'hC2; init_mem[5] = 8'hC5;
    init_mem[20] = val;
    push_q.push_back(val);
    do_reset();
    repeat (7) tick();
    checks++;
    if (pc !== exp_pc || depth !== 4'd1) begin
      errors++;
      $display("FAIL jz_tos_%02h: got pc=%0d depth=%0d, required pc=%0d depth=1",
               val, pc, depth, exp_pc);
    end
    checks++;
    if (push_q.size() != 0) begin
      errors++;
      $display("FAIL jz_pending: got %0d pushes left, required 0", push_q.size());
    end
    push_q.delete();
  endtask

  task automatic test_underflow();
    clear_mem();
    init_mem[0] = 8'h00;
    do_reset();
    tick();
    checks++;
    if (halted !== 1'b0) begin
      errors++;
      $display("FAIL underflow_in_id: got halted=%b, required 0", halted);
    end
    tick();
    checks++;
    if (halted !== 1'b1 || depth !== 4'd0) begin
      errors++;
      $display("FAIL underflow_halt: got halted=%b depth=%0d, required 1 0", halted, depth);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (strobes !== 13'd0 || halted !== 1'b1) begin
        errors++;
        $display("FAIL err_quiet_%0d: got strobes=%h halted=%b, required 0 1", i, strobes, halted);
      end
    end
    rst = 1'b1;
    #1;
    checks++;
    if (halted !== 1'b0 || depth !== 4'd0) begin
      errors++;
      $display("FAIL err_reset: got halted=%b depth=%0d, required 0 0", halted, depth);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (!(mem_read === 1'b1 && ir_write === 1'b1 && addr === 5'd0 && halted === 1'b0)) begin
      errors++;
      $display("FAIL err_restart: got strobes=%h addr=%0d halted=%b, required IF at 0",
               strobes, addr, halted);
    end
  endtask

  task automatic test_overflow();
    clear_mem();
    for (int i = 0; i < 9; i++) begin
      init_mem[i] = 8'h80 | 8'(20 + i);
      init_mem[20 + i] = 8'(8'h11 * (i + 1));
      if (i < 8) push_q.push_back(8'(8'h11 * (i + 1)));
    end
    do_reset();
    repeat (32) tick();
    checks++;
    if (depth !== 4'd8 || halted !== 1'b0) begin
      errors++;
      $display("FAIL overflow_full: got depth=%0d halted=%b, required 8 0", depth, halted);
    end
    repeat (2) tick();
    checks++;
    if (depth !== 4'd8 || halted !== 1'b1) begin
      errors++;
      $display("FAIL overflow_halt: got depth=%0d halted=%b, required 8 1", depth, halted);
    end
    repeat (6) tick();
    checks++;
    if (push_q.size() != 0 || depth !== 4'd8) begin
      errors++;
      $display("FAIL overflow_pending: got %0d pushes left depth=%0d, required 0 8",
               push_q.size(), depth);
    end
    push_q.delete();
  endtask

  task automatic test_reset_mid_instr();
    clear_mem();
    init_mem[0] = 8'h8F; init_mem[1] = 8'h90; init_mem[2] = 8'h00;
    init_mem[15] = 8'd7; init_mem[16] = 8'd10;
    push_q.push_back(8'd7); push_q.push_back(8'd10);
    do_reset();
    repeat (11) tick();
    checks++;
    if (stack_pop !== 1'b1 || b_load !== 1'b1) begin
      errors++;
      $display("FAIL popb_reached: got pop=%b b_load=%b, required 1 1", stack_pop, b_load);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (strobes !== 13'd0) begin
      errors++;
      $display("FAIL mid_reset_strobes: got %h, required 0", strobes);
    end
    tick();
    checks++;
    if (depth !== 4'd0 || sp !== 5'd0) begin
      errors++;
      $display("FAIL mid_reset_depth: got depth=%0d sp=%0d, required 0 0", depth, sp);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (!(mem_read === 1'b1 && iord === 1'b0 && addr === 5'd0)) begin
      errors++;
      $display("FAIL mid_reset_refetch: got mem_read=%b iord=%b addr=%0d, required 1 0 0",
               mem_read, iord, addr);
    end
    push_q.push_back(8'd7); push_q.push_back(8'd10);
    repeat (8) tick();
    checks++;
    if (depth !== 4'd2 || push_q.size() != 0) begin
      errors++;
      $display("FAIL mid_reset_rerun: got depth=%0d pending=%0d, required 2 0",
               depth, push_q.size());
    end
    push_q.delete();
  endtask

  initial begin
    test_reset();
    test_add_pop();
    test_sub_not();
    test_jz(8'd0, 5'd5);
    test_jz(8'd3, 5'd2);
    test_underflow();
    test_overflow();
    test_reset_mid_instr();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
